// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds the data width, the NOP encoding shown to decode when the prefetch buffer
// is empty, the fetch FSM state encoding, and a word-alignment helper.
package instruction_fetch_unit_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } ifu_state_e;

  // Clear the byte offset so every fetch address is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] i_addr);
    return {i_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Prefetch buffer between instruction memory and decode.
// Ports:
//   clk, rst_n    clock and synchronous active-low reset
//   i_clear       synchronous flush (wins over push/pop in the same cycle)
//   i_push        write i_push_data at the tail
//   i_pop         remove the head entry
//   o_valid       buffer holds at least one entry
//   o_head_data   head entry (straight from storage, no bypass from push)
//   o_count       number of stored entries
module instruction_fetch_unit_fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_head_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign w_push = i_push && ((r_count != (AW+1)'(DEPTH)) || w_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid     = (r_count != '0);
  assign o_head_data = r_mem[r_rd_ptr];
  assign o_count     = r_count;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, issues in-order word reads to instruction memory,
// buffers returned words and presents {instruction, inst_pc} to decode.
// Redirects flush the buffer and discard responses still in flight.
// Ports:
//   clk, rst_n                              clock, synchronous active-low reset
//   imem_req_valid/ready/addr               fetch request channel
//   imem_rsp_valid/data                     in-order read response
//   redirect_valid/pc                       branch/jump redirect pulse from execute
//   inst_valid/ready, instruction, inst_pc  handshake toward decode
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] inst_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e      r_state;
  ifu_state_e      w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [XLEN-1:0] r_stale_addr;
  logic            r_stale_pend;
  logic [CW-1:0]   r_outst;
  logic [CW-1:0]   r_drop;
  logic [CW-1:0]   w_outst_nxt;
  logic [CW-1:0]   w_drop_nxt;
  logic [CW-1:0]   w_count;
  logic            w_fifo_valid;
  logic [63:0]     w_head;
  logic            w_credit;
  logic            w_req_valid;
  logic            w_accept;
  logic            w_rsp;
  logic            w_push;
  logic            w_pop;
  logic            w_drop_dec;

  // Outstanding requests are counted against buffer space, so every response
  // that comes back is guaranteed a slot.
  assign w_credit    = ({1'b0, w_count} + {1'b0, r_outst}) < (CW+1)'(FIFO_DEPTH);
  // A request that survived a redirect stays valid until memory takes it.
  assign w_req_valid = (r_state != ST_BOOT) && (r_stale_pend || w_credit);
  assign w_accept    = w_req_valid && imem_req_ready;
  // Responses with nothing outstanding (e.g. straight after reset) are ignored.
  assign w_rsp       = imem_rsp_valid && (r_outst != '0);
  assign w_drop_dec  = w_rsp && (r_drop != '0);
  assign w_push      = w_rsp && (r_drop == '0) && !redirect_valid;
  assign w_pop       = w_fifo_valid && inst_ready;

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_stale_pend ? r_stale_addr : r_fetch_pc;

  // Next FSM state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_valid && ((r_outst != '0) || w_accept)) begin
          w_state_nxt = ST_FLUSH;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (redirect_valid) begin
          w_state_nxt = ST_FLUSH;
        end else if (r_drop == '0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_FLUSH;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  // Outstanding and drop counters for the coming cycle.
  always_comb begin
    w_outst_nxt = r_outst + {{(CW-1){1'b0}}, w_accept} - {{(CW-1){1'b0}}, w_rsp};
    w_drop_nxt  = r_drop;
    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      w_drop_nxt = w_outst_nxt;
    end else begin
      // A stale request accepted late is also on the old path.
      w_drop_nxt = r_drop - {{(CW-1){1'b0}}, w_drop_dec}
                 + {{(CW-1){1'b0}}, (w_accept && r_stale_pend)};
    end
  end

  // FSM, PC tracking and in-flight bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_BOOT;
      r_fetch_pc   <= RESET_PC;
      r_rsp_pc     <= RESET_PC;
      r_stale_addr <= RESET_PC;
      r_stale_pend <= 1'b0;
      r_outst      <= '0;
      r_drop       <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_outst <= w_outst_nxt;
      r_drop  <= w_drop_nxt;
      if (redirect_valid) begin
        r_fetch_pc   <= word_align(redirect_pc);
        r_rsp_pc     <= word_align(redirect_pc);
        r_stale_pend <= w_req_valid && !imem_req_ready;
        r_stale_addr <= imem_req_addr;
      end else begin
        if (w_accept && !r_stale_pend) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_accept) begin
          r_stale_pend <= 1'b0;
        end
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + 32'd4;
        end
      end
    end
  end

  instruction_fetch_unit_fetch_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (redirect_valid),
    .i_push      (w_push),
    .i_push_data ({imem_rsp_data, r_rsp_pc}),
    .i_pop       (w_pop),
    .o_valid     (w_fifo_valid),
    .o_head_data (w_head),
    .o_count     (w_count)
  );

  assign inst_valid  = w_fifo_valid;
  assign instruction = w_fifo_valid ? w_head[63:32] : INST_NOP;
  assign inst_pc     = w_fifo_valid ? w_head[31:0]  : 32'h0000_0000;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;

  logic        rst2_n;
  logic        d2_req_valid;
  logic [31:0] d2_req_addr;
  logic        d2_inst_valid;
  logic [31:0] d2_instruction;
  logic [31:0] d2_inst_pc;

  int          n_pass;
  int          n_fail;
  int          n_total;
  int          n_deliv;
  int          base;
  int          cyc;
  int          lat;
  logic [31:0] exp_pc;
  logic [31:0] held_addr;
  logic        rd_req;
  logic [31:0] rd_pc;
  req_t        mq[$];
  logic [31:0] acc_log[$];

  instruction_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .instruction    (instruction),
    .inst_pc        (inst_pc)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut2 (
    .clk            (clk),
    .rst_n          (rst2_n),
    .imem_req_valid (d2_req_valid),
    .imem_req_ready (1'b1),
    .imem_req_addr  (d2_req_addr),
    .imem_rsp_valid (1'b0),
    .imem_rsp_data  (32'h0000_0000),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0000_0000),
    .inst_valid     (d2_inst_valid),
    .inst_ready     (1'b0),
    .instruction    (d2_instruction),
    .inst_pc        (d2_inst_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h00AA_5500;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: memory model response, redirect drive, accept/pop capture.
  task automatic step();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memfn(mq[0].addr);
      mq.delete(0);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    redirect_valid = rd_req;
    redirect_pc    = rd_pc;
    #1;
    if (rst_n && imem_req_valid && imem_req_ready) begin
      req_t e;
      e.addr = imem_req_addr;
      e.due  = cyc + lat;
      mq.push_back(e);
      acc_log.push_back(imem_req_addr);
    end
    if (rst_n && inst_valid && inst_ready) begin
      chk("stream_pc", inst_pc, exp_pc);
      chk("stream_data", instruction, memfn(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_deliv++;
    end
    if (rd_req) exp_pc = {rd_pc[31:2], 2'b00};
    rd_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (!rst_n) mq.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    chk({tag, "_req_addr"}, imem_req_addr, 32'h0000_0000);
    chk({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, "_instruction"}, instruction, 32'h0000_0013);
    chk({tag, "_inst_pc"}, inst_pc, 32'h0000_0000);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    mq.delete();
    acc_log.delete();
    n_deliv = 0;
    exp_pc  = 32'h0000_0000;
    check_reset_outputs("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0; n_deliv = 0; base = 0; cyc = 0; lat = 1;
    rst_n = 1'b0; rst2_n = 1'b0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;
    rd_req = 1'b0; rd_pc = 32'h0; exp_pc = 32'h0; held_addr = 32'h0;
    @(negedge clk);

    // Test 1: streaming with 1-cycle memory
    lat = 1; inst_ready = 1'b1;
    do_reset();
    chk("t1_boot_no_req", {31'd0, imem_req_valid}, 32'd0);
    step();
    chk("t1_req0_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t1_req0_addr", imem_req_addr, 32'h0000_0000);
    step();
    chk("t1_req1_addr", imem_req_addr, 32'h0000_0004);
    chk("t1_not_yet_valid", {31'd0, inst_valid}, 32'd0);
    step();
    chk("t1_first_valid", {31'd0, inst_valid}, 32'd1);
    chk("t1_first_pc", inst_pc, 32'h0000_0000);
    for (int i = 0; i < 6; i++) step();
    chk("t1_delivered", n_deliv, 32'd6);

    // Test 2: decoder stalled, credit limit, drain
    inst_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) step();
    chk("t2_req_count", acc_log.size(), 32'd4);
    chk("t2_req_stopped", {31'd0, imem_req_valid}, 32'd0);
    chk("t2_head_valid", {31'd0, inst_valid}, 32'd1);
    chk("t2_head_pc", inst_pc, 32'h0000_0000);
    inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("t2_drained", n_deliv, 32'd10);
    chk("t2_resume_addr", acc_log[4], 32'h0000_0010);

    // Test 3: 3-cycle memory, redirect with two outstanding
    lat = 3; inst_ready = 1'b1;
    do_reset();
    step();
    step();
    rd_req = 1'b1; rd_pc = 32'h0000_0100;
    step();
    chk("t3_new_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t3_new_req_addr", imem_req_addr, 32'h0000_0100);
    step();
    step();
    step();
    chk("t3_no_stale", {31'd0, inst_valid}, 32'd0);
    step();
    chk("t3_target_valid", {31'd0, inst_valid}, 32'd1);
    chk("t3_target_pc", inst_pc, 32'h0000_0100);
    for (int i = 0; i < 6; i++) step();

    // Test 4: redirect coincident with response and pop, unaligned target
    lat = 1; inst_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    chk("t4_pop_in_redirect", {31'd0, inst_valid}, 32'd1);
    base = n_deliv;
    rd_req = 1'b1; rd_pc = 32'h0000_0203;
    step();
    chk("t4_popped_delivered", n_deliv - base, 32'd1);
    chk("t4_flushed", {31'd0, inst_valid}, 32'd0);
    chk("t4_new_req_addr", imem_req_addr, 32'h0000_0200);
    step();
    chk("t4_rsp_dropped", {31'd0, inst_valid}, 32'd0);
    step();
    chk("t4_target_valid", {31'd0, inst_valid}, 32'd1);
    chk("t4_target_pc", inst_pc, 32'h0000_0200);
    for (int i = 0; i < 4; i++) step();

    // Test 5: memory stall with redirect mid-stall
    lat = 1; inst_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    imem_req_ready = 1'b0;
    held_addr = 32'h0000_000C;
    for (int i = 0; i < 5; i++) begin
      chk("t5_stall_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("t5_stall_addr", imem_req_addr, held_addr);
      if (i == 2) begin
        rd_req = 1'b1;
        rd_pc  = 32'h0000_0300;
      end
      step();
      if (i == 2) base = n_deliv;
    end
    imem_req_ready = 1'b1;
    chk("t5_stale_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t5_stale_addr", imem_req_addr, held_addr);
    step();
    chk("t5_target_addr", imem_req_addr, 32'h0000_0300);
    for (int i = 0; i < 6; i++) step();
    chk("t5_target_words", n_deliv - base, 32'd4);

    // Test 6b: reset asserted during a flush
    lat = 3; inst_ready = 1'b1;
    do_reset();
    step();
    step();
    rd_req = 1'b1; rd_pc = 32'h0000_0100;
    step();
    rst_n = 1'b0;
    step();
    check_reset_outputs("t6_midflush");
    rst_n = 1'b1;
    exp_pc = 32'h0000_0000;
    chk("t6_boot_no_req", {31'd0, imem_req_valid}, 32'd0);
    step();
    chk("t6_restart_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t6_restart_addr", imem_req_addr, 32'h0000_0000);
    step();

    // Test 6a: reset PC near the top of the address space wraps to 0
    chk("t6w_rst_valid", {31'd0, d2_req_valid}, 32'd0);
    chk("t6w_rst_addr", d2_req_addr, 32'hFFFF_FFF8);
    rst2_n = 1'b1;
    step();
    chk("t6w_req0_valid", {31'd0, d2_req_valid}, 32'd1);
    chk("t6w_req0_addr", d2_req_addr, 32'hFFFF_FFF8);
    step();
    chk("t6w_req1_addr", d2_req_addr, 32'hFFFF_FFFC);
    step();
    chk("t6w_req2_addr", d2_req_addr, 32'h0000_0000);
    chk("t6w_inst_valid", {31'd0, d2_inst_valid}, 32'd0);
    chk("t6w_instruction", d2_instruction, 32'h0000_0013);
    chk("t6w_inst_pc", d2_inst_pc, 32'h0000_0000);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
